// File: rtl/leading_bits_pkg.sv
// Shared types for the leading-bits scheduler: count-op encoding and op decode helper.
package leading_bits_pkg;

  typedef enum logic [1:0] {
    LBC_OP_CLZ = 2'b00,
    LBC_OP_CLO = 2'b01,
    LBC_OP_CTZ = 2'b10,
    LBC_OP_CTO = 2'b11
  } lbc_op_t;

  function automatic logic lbc_counts_ones(input lbc_op_t op);
    return op[0];
  endfunction

endpackage

// File: rtl/leading_bits_counter.sv
// Combinational leading-bit counter: number of BIT_TO_COUNT bits above the first differing bit.
// The count is meaningless when the operand is entirely BIT_TO_COUNT; use 'all' in that case.
module leading_bits_counter #(
  parameter int DATA_WIDTH   = 64,
  parameter bit BIT_TO_COUNT = 1'b0,
  parameter int COUNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0]  data,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   all
);

  // Later (higher) differing bits overwrite earlier ones, leaving the MSB-most position.
  always_comb begin
    count = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (data[i] != BIT_TO_COUNT) count = COUNT_WIDTH'(DATA_WIDTH - 1 - i);
    end
  end

  assign all = (data == {DATA_WIDTH{BIT_TO_COUNT}});

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer, pointer moves past
// the winner only when the grant is actually taken.
module round_robin_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      advance,
  output logic [NUM_REQUESTERS-1:0] grant,
  output logic [ID_WIDTH-1:0]       grant_index,
  output logic                      grant_valid
);

  logic [ID_WIDTH-1:0] ptr;

  // Scan from the farthest offset down so the nearest request at/after ptr wins last.
  always_comb begin
    int idx;
    idx         = 0;
    grant_index = '0;
    grant_valid = 1'b0;
    for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQUESTERS;
      if (request[idx]) begin
        grant_valid = 1'b1;
        grant_index = ID_WIDTH'(idx);
      end
    end
    grant = grant_valid ? (NUM_REQUESTERS'(1) << grant_index) : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(grant_index) == NUM_REQUESTERS - 1) ? '0 : grant_index + 1'b1;
    end
  end

endmodule

// File: rtl/leading_bits_scheduler.sv
// Shares one leading-zero counter among NUM_REQUESTERS clients through a round-robin,
// 2-stage valid/ready pipeline. Define LEADING_BITS_TRAILING_EN to enable CTZ/CTO ops.
module leading_bits_scheduler
  import leading_bits_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 64,
  parameter int COUNT_WIDTH    = $clog2(DATA_WIDTH) + 1,
  parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS)
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic [NUM_REQUESTERS-1:0]            request_valid,
  output logic [NUM_REQUESTERS-1:0]            request_ready,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] request_data,
  input  logic [NUM_REQUESTERS*2-1:0]          request_op,
  output logic                                 response_valid,
  input  logic                                 response_ready,
  output logic [ID_WIDTH-1:0]                  response_id,
  output logic [COUNT_WIDTH-1:0]               response_count,
  output logic                                 response_all
);

  localparam int RAW_WIDTH = $clog2(DATA_WIDTH);

  // The counter's raw value cannot represent DATA_WIDTH, so an all-match overrides it.
  function automatic logic [COUNT_WIDTH-1:0] full_range_count(input logic [RAW_WIDTH-1:0] raw,
                                                             input logic all);
    return all ? COUNT_WIDTH'(DATA_WIDTH) : COUNT_WIDTH'(raw);
  endfunction

  logic [NUM_REQUESTERS-1:0] grant;
  logic [ID_WIDTH-1:0]       grant_index;
  logic                      grant_valid;
  logic                      vld_p1;
  logic                      adv_p2;
  logic                      load_p1;
  logic                      accept;
  logic [ID_WIDTH-1:0]       id_p1;
  logic [DATA_WIDTH-1:0]     operand_p1;
  lbc_op_t                   op_p1;
  logic [DATA_WIDTH-1:0]     operand_sel;
  lbc_op_t                   op_sel;
  logic [DATA_WIDTH-1:0]     count_in;
  logic [RAW_WIDTH-1:0]      raw_count;
  logic                      raw_all;

  assign adv_p2        = !response_valid || response_ready;
  assign load_p1       = !vld_p1 || adv_p2;
  assign request_ready = grant & {NUM_REQUESTERS{load_p1 && reset_n}};
  assign accept        = |request_ready;

  round_robin_arbiter #(
    .NUM_REQUESTERS(NUM_REQUESTERS),
    .ID_WIDTH      (ID_WIDTH)
  ) u_arbiter (
    .clock      (clock),
    .reset_n    (reset_n),
    .request    (request_valid),
    .advance    (accept),
    .grant      (grant),
    .grant_index(grant_index),
    .grant_valid(grant_valid)
  );

  always_comb begin
    operand_sel = request_data[int'(grant_index)*DATA_WIDTH +: DATA_WIDTH];
    op_sel      = lbc_op_t'(request_op[int'(grant_index)*2 +: 2]);
  end

  // ---- stage 1: operand register ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
    end else if (load_p1) begin
      vld_p1 <= accept;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      id_p1      <= grant_index;
      operand_p1 <= operand_sel;
      op_p1      <= op_sel;
    end
  end

  // Counting ones becomes counting zeros by inversion; trailing counts by bit reversal.
`ifdef LEADING_BITS_TRAILING_EN
  always_comb begin
    logic [DATA_WIDTH-1:0] inv;
    inv      = operand_p1 ^ {DATA_WIDTH{lbc_counts_ones(op_p1)}};
    count_in = inv;
    if (op_p1[1]) begin
      for (int i = 0; i < DATA_WIDTH; i++) count_in[i] = inv[DATA_WIDTH-1-i];
    end
  end
`else
  logic unused_op_hi;
  assign unused_op_hi = op_p1[1];
  assign count_in     = operand_p1 ^ {DATA_WIDTH{lbc_counts_ones(op_p1)}};
`endif

  leading_bits_counter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BIT_TO_COUNT(1'b0),
    .COUNT_WIDTH (RAW_WIDTH)
  ) u_counter (
    .data (count_in),
    .count(raw_count),
    .all  (raw_all)
  );

  // ---- stage 2: result register, drives the response channel ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      response_valid <= 1'b0;
      response_id    <= '0;
      response_count <= '0;
      response_all   <= 1'b0;
    end else if (adv_p2) begin
      response_valid <= vld_p1;
      if (vld_p1) begin
        response_id    <= id_p1;
        response_count <= full_range_count(raw_count, raw_all);
        response_all   <= raw_all;
      end
    end
  end

endmodule
